// File: rtl/mem_initiator_if.sv
// CPU-side request/response bundle for mem_initiator.
//   master : control unit  (drives req, we, cpu_addr, cpu_wdata)
//   slave  : mem_initiator (drives ready, done, cpu_rdata)
// Signals:
//   req        request strobe, sampled only while ready=1
//   we         1 = write, 0 = read, qualified by req
//   cpu_addr   word address
//   cpu_wdata  write data
//   ready      a request can be accepted this cycle
//   done       one-cycle completion pulse
//   cpu_rdata  read data, held until the next read completes
interface mem_initiator_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_SPACE = 9
);
    logic                  req;
    logic                  we;
    logic [ADDR_SPACE-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  ready;
    logic                  done;
    logic [DATA_WIDTH-1:0] cpu_rdata;

    modport master (
        output req, we, cpu_addr, cpu_wdata,
        input  ready, done, cpu_rdata
    );

    modport slave (
        input  req, we, cpu_addr, cpu_wdata,
        output ready, done, cpu_rdata
    );
endinterface

// File: rtl/mem_initiator.sv
// Memory access unit between the control unit and an enable-edge RAM.
// Turns a single-cycle request into a setup / enable-pulse / hold sequence
// and reports completion with a one-cycle done pulse. A one-entry pending
// slot lets the next request be queued while an access is in flight.
// Ports:
//   clock        system clock, rising edge
//   clear        synchronous active-high reset
//   cpu          mem_initiator_if.slave (req/we/addr/wdata in, ready/done/rdata out)
//   ram_addr     RAM address
//   ram_datain   RAM write data
//   ram_read     RAM read select
//   ram_write    RAM write select
//   ram_enable   RAM enable, one single-cycle pulse per access
//   ram_dataout  RAM read data
//
// state  | meaning
// IDLE   | no access in flight; launches a pending or new request
// SETUP  | address/data/read/write presented, enable low
// STROBE | enable high, RAM acts on its rising edge
// HOLD   | enable low, bus held; completion registered on exit
module mem_initiator #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_SPACE = 9
) (
    input  logic                  clock,
    input  logic                  clear,
    mem_initiator_if.slave        cpu,
    output logic [ADDR_SPACE-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_datain,
    output logic                  ram_read,
    output logic                  ram_write,
    output logic                  ram_enable,
    input  logic [DATA_WIDTH-1:0] ram_dataout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t                state_q, state_n;
    logic                  pend_valid_q, pend_valid_n;
    logic                  pend_we_q, pend_we_n;
    logic [ADDR_SPACE-1:0] pend_addr_q, pend_addr_n;
    logic [DATA_WIDTH-1:0] pend_wdata_q, pend_wdata_n;
    logic                  ready_q, ready_n;
    logic                  done_q, done_n;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_n;
    logic [ADDR_SPACE-1:0] addr_n;
    logic [DATA_WIDTH-1:0] datain_n;
    logic                  read_n, write_n, enable_n;

    logic accept, launch_pend, launch_new;

    // ready mirrors an empty pending slot, so a pending launch and a new
    // acceptance can never coincide.
    assign accept      = cpu.req && ready_q;
    assign launch_pend = (state_q == IDLE) && pend_valid_q;
    assign launch_new  = (state_q == IDLE) && !pend_valid_q && accept;

    always_comb begin
        state_n      = state_q;
        pend_valid_n = pend_valid_q;
        pend_we_n    = pend_we_q;
        pend_addr_n  = pend_addr_q;
        pend_wdata_n = pend_wdata_q;
        done_n       = 1'b0;
        rdata_n      = rdata_q;
        addr_n       = ram_addr;
        datain_n     = ram_datain;
        read_n       = ram_read;
        write_n      = ram_write;
        enable_n     = 1'b0;

        if (accept && !launch_new) begin
            pend_valid_n = 1'b1;
            pend_we_n    = cpu.we;
            pend_addr_n  = cpu.cpu_addr;
            pend_wdata_n = cpu.cpu_wdata;
        end

        case (state_q)
            IDLE: begin
                if (launch_pend) begin
                    pend_valid_n = 1'b0;
                    addr_n       = pend_addr_q;
                    datain_n     = pend_wdata_q;
                    read_n       = !pend_we_q;
                    write_n      = pend_we_q;
                    state_n      = SETUP;
                end else if (launch_new) begin
                    addr_n   = cpu.cpu_addr;
                    datain_n = cpu.cpu_wdata;
                    read_n   = !cpu.we;
                    write_n  = cpu.we;
                    state_n  = SETUP;
                end
            end
            SETUP: begin
                enable_n = 1'b1;
                state_n  = STROBE;
            end
            STROBE: begin
                state_n = HOLD;
            end
            HOLD: begin
                if (ram_read) begin
                    rdata_n = ram_dataout;
                end
                read_n  = 1'b0;
                write_n = 1'b0;
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        ready_n = !pend_valid_n;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q      <= IDLE;
            pend_valid_q <= 1'b0;
            pend_we_q    <= 1'b0;
            pend_addr_q  <= '0;
            pend_wdata_q <= '0;
            ready_q      <= 1'b1;
            done_q       <= 1'b0;
            rdata_q      <= '0;
            ram_addr     <= '0;
            ram_datain   <= '0;
            ram_read     <= 1'b0;
            ram_write    <= 1'b0;
            ram_enable   <= 1'b0;
        end else begin
            state_q      <= state_n;
            pend_valid_q <= pend_valid_n;
            pend_we_q    <= pend_we_n;
            pend_addr_q  <= pend_addr_n;
            pend_wdata_q <= pend_wdata_n;
            ready_q      <= ready_n;
            done_q       <= done_n;
            rdata_q      <= rdata_n;
            ram_addr     <= addr_n;
            ram_datain   <= datain_n;
            ram_read     <= read_n;
            ram_write    <= write_n;
            ram_enable   <= enable_n;
        end
    end

    assign cpu.ready     = ready_q;
    assign cpu.done      = done_q;
    assign cpu.cpu_rdata = rdata_q;

endmodule
